// File: rtl/cpld_xnor_parity_rx_pkg.sv
// Shared definitions for the CPLD XNOR-parity serial link: receiver FSM
// states, line-level constants and a reference XNOR parity helper that the
// transmit side can reuse.
package cpld_parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Reduction XNOR over the low w bits of d; an all-zero (or empty) word
  // gives 1, matching ~^ for the even-ones case.
  function automatic logic xnor_par(logic [15:0] d, int w);
    logic p;
    p = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < w) p = p ^ d[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/cpld_xnor_parity_rx_if.sv
// Receive-side bundle of the CPLD serial link. The master drives the bit
// strobe and line; the slave (receiver) returns the decoded frame status.
interface cpld_xnor_parity_rx_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
);
  logic              bit_en;
  logic              sin;
  logic [DATA_W-1:0] dout;
  logic              dvalid;
  logic              perr;
  logic              ferr;
  logic              busy;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output bit_en, sin,
    input  dout, dvalid, perr, ferr, busy, err_cnt
  );

  modport slave (
    input  bit_en, sin,
    output dout, dvalid, perr, ferr, busy, err_cnt
  );
endinterface

// File: rtl/cpld_xnor_parity_gen.sv
// Combinational XNOR parity over a W-bit word: 1 when the word holds an
// even number of ones. Shared between the link transmitter and receiver.
module cpld_xnor_parity_gen #(
  parameter int W = 4
) (
  input  logic [W-1:0] d,
  output logic         par
);

  assign par = ~^d;

endmodule

// File: rtl/cpld_xnor_parity_rx.sv
// Serial receiver for XNOR-parity frames: start(0), DATA_W data bits LSB
// first, parity bit, stop(1), one line bit per BIT_EN strobe.
// Optional feature macro: CPLD_PARITY_RX_CNT_EN builds a saturating error
// counter on err_cnt; without it err_cnt is tied to zero.
module cpld_xnor_parity_rx
  import cpld_parity_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  cpld_xnor_parity_rx_if.slave  bus
);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shnext;
  logic [4:0]        cnt;
  logic              rx_par;
  logic              exp_par;
  logic [DATA_W-1:0] dout;
  logic              dvalid;
  logic              perr;
  logic              ferr;
  logic              frame_bad;

  // A one-bit payload has nothing to shift down, so it just takes the line.
  generate
    if (DATA_W == 1) begin : g_sh1
      assign shnext = bus.sin;
    end else begin : g_shn
      assign shnext = {bus.sin, shreg[DATA_W-1:1]};
    end
  endgenerate

  cpld_xnor_parity_gen #(.W(DATA_W)) u_gen (
    .d   (shreg),
    .par (exp_par)
  );

  assign frame_bad = (rx_par != exp_par) || (bus.sin != STOP_BIT);

  // Frame FSM: advances only on strobed cycles and reports the frame one
  // cycle after the stop bit is sampled; a bad stop bit still ends the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      rx_par <= 1'b0;
      dout   <= '0;
      dvalid <= 1'b0;
      perr   <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      dvalid <= 1'b0;
      if (bus.bit_en) begin
        case (state)
          IDLE: begin
            if (bus.sin == START_BIT) begin
              state <= DATA;
              cnt   <= '0;
            end
          end
          DATA: begin
            shreg <= shnext;
            cnt   <= cnt + 5'd1;
            if (cnt == 5'(DATA_W - 1)) state <= PARITY;
          end
          PARITY: begin
            rx_par <= bus.sin;
            state  <= STOP;
          end
          STOP: begin
            dout   <= shreg;
            perr   <= (rx_par != exp_par);
            ferr   <= (bus.sin != STOP_BIT);
            dvalid <= 1'b1;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.dout   = dout;
  assign bus.dvalid = dvalid;
  assign bus.perr   = perr;
  assign bus.ferr   = ferr;
  assign bus.busy   = (state != IDLE);

`ifdef CPLD_PARITY_RX_CNT_EN
  logic [CNT_W-1:0] err_cnt;

  // Saturating count of bad frames, stepped on the same edge that raises
  // dvalid so the count is current while the frame is being reported.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (bus.bit_en && state == STOP && frame_bad && err_cnt != '1) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  assign bus.err_cnt = err_cnt;
`else
  logic unused_frame_bad;
  assign unused_frame_bad = frame_bad;
  assign bus.err_cnt      = '0;
`endif

endmodule

// File: tb/tb_cpld_xnor_parity_rx.sv
// Directed bench for cpld_xnor_parity_rx (DATA_W=4, CNT_W=2): a vector
// table of whole frames plus hand sequences for back-to-back frames after a
// framing error and for reset in the middle of a frame.
module tb_cpld_xnor_parity_rx;

  logic clk;
  logic rst;

  cpld_xnor_parity_rx_if #(.DATA_W(4), .CNT_W(2)) bus ();

  cpld_xnor_parity_rx #(.DATA_W(4), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

`ifdef CPLD_PARITY_RX_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0] data;
    logic       par;
    logic       stop;
    int         spacing;
    logic [3:0] expDout;
    logic       expPerr;
    logic       expFerr;
    int         expBusy;
  } vec_t;

  vec_t vecs[8];
  int   compared;
  int   mismatched;
  int   expErr;
  int   busyCyc;
  int   dvCyc;
  int   quietDv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives one frame, strobing every 'spacing' cycles; counts busy and
  // dvalid cycles seen at negedges while the frame is on the line. Returns
  // right after driving the stop bit (it is consumed at the next posedge).
  task automatic applyStimulus(input logic [3:0] d, input logic p, input logic s,
                               input int spacing, output int nBusy, output int nDv);
    logic [6:0] bits;
    bits  = {s, p, d, 1'b0};
    nBusy = 0;
    nDv   = 0;
    for (int i = 0; i < 7; i++) begin
      for (int g = 0; g < spacing; g++) begin
        @(negedge clk);
        if (bus.busy)   nBusy++;
        if (bus.dvalid) nDv++;
        bus.bit_en = (g == spacing - 1);
        bus.sin    = bits[i];
      end
    end
  endtask

  task automatic idleLine();
    bus.bit_en = 1'b0;
    bus.sin    = 1'b1;
  endtask

  // Bad frames step the expected error count, saturating at 3 for CNT_W=2.
  task automatic bumpErr(input logic bad);
    if (CNT_EN && bad && expErr < 3) expErr++;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    expErr     = 0;

    // Data bits are LSB first; expected parity is 1 for an even count of ones.
    vecs[0] = '{4'hD, 1'b1, 1'b1, 1, 4'hD, 1'b1, 1'b0, 6};
    vecs[1] = '{4'h3, 1'b1, 1'b1, 1, 4'h3, 1'b0, 1'b0, 6};
    vecs[2] = '{4'h3, 1'b1, 1'b0, 1, 4'h3, 1'b0, 1'b1, 6};
    vecs[3] = '{4'hF, 1'b1, 1'b1, 3, 4'hF, 1'b0, 1'b0, 18};
    vecs[4] = '{4'h0, 1'b1, 1'b1, 1, 4'h0, 1'b0, 1'b0, 6};
    vecs[5] = '{4'h0, 1'b0, 1'b1, 1, 4'h0, 1'b1, 1'b0, 6};
    vecs[6] = '{4'h8, 1'b0, 1'b1, 2, 4'h8, 1'b0, 1'b0, 12};
    vecs[7] = '{4'h6, 1'b0, 1'b0, 1, 4'h6, 1'b1, 1'b1, 6};

    rst = 1'b1;
    idleLine();
    repeat (3) @(negedge clk);
    checkOutput("reset dout", 32'(bus.dout), 32'h0);
    checkOutput("reset dvalid", 32'(bus.dvalid), 32'h0);
    checkOutput("reset perr", 32'(bus.perr), 32'h0);
    checkOutput("reset ferr", 32'(bus.ferr), 32'h0);
    checkOutput("reset busy", 32'(bus.busy), 32'h0);
    checkOutput("reset err_cnt", 32'(bus.err_cnt), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle busy", 32'(bus.busy), 32'h0);

    // Table of single frames, each followed by an idle line.
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].data, vecs[v].par, vecs[v].stop, vecs[v].spacing, busyCyc, dvCyc);
      @(negedge clk);
      bumpErr(vecs[v].expPerr | vecs[v].expFerr);
      checkOutput($sformatf("v%0d dvalid", v), 32'(bus.dvalid), 32'h1);
      checkOutput($sformatf("v%0d dout", v), 32'(bus.dout), 32'(vecs[v].expDout));
      checkOutput($sformatf("v%0d perr", v), 32'(bus.perr), 32'(vecs[v].expPerr));
      checkOutput($sformatf("v%0d ferr", v), 32'(bus.ferr), 32'(vecs[v].expFerr));
      checkOutput($sformatf("v%0d err_cnt", v), 32'(bus.err_cnt), 32'(expErr));
      checkOutput($sformatf("v%0d busy cycles", v), 32'(busyCyc), 32'(vecs[v].expBusy));
      checkOutput($sformatf("v%0d early dvalid", v), 32'(dvCyc), 32'h0);
      idleLine();
      @(negedge clk);
      checkOutput($sformatf("v%0d dvalid drop", v), 32'(bus.dvalid), 32'h0);
      checkOutput($sformatf("v%0d busy after", v), 32'(bus.busy), 32'h0);
    end

    // Framing error immediately followed by a start bit on the next strobe.
    applyStimulus(4'h3, 1'b1, 1'b0, 1, busyCyc, dvCyc);
    bumpErr(1'b1);
    applyStimulus(4'h5, 1'b1, 1'b1, 1, busyCyc, dvCyc);
    checkOutput("b2b first dvalid count", 32'(dvCyc), 32'h1);
    checkOutput("b2b first ferr", 32'(bus.ferr), 32'h1);
    checkOutput("b2b first dout", 32'(bus.dout), 32'h3);
    checkOutput("b2b busy cycles", 32'(busyCyc), 32'h6);
    @(negedge clk);
    idleLine();
    checkOutput("b2b second dvalid", 32'(bus.dvalid), 32'h1);
    checkOutput("b2b second dout", 32'(bus.dout), 32'h5);
    checkOutput("b2b second perr", 32'(bus.perr), 32'h0);
    checkOutput("b2b second ferr", 32'(bus.ferr), 32'h0);
    checkOutput("b2b err_cnt", 32'(bus.err_cnt), 32'(expErr));

    // Reset after the second data bit discards the frame silently.
    @(negedge clk);
    bus.bit_en = 1'b1;
    bus.sin    = 1'b0;
    @(negedge clk);
    bus.sin    = 1'b1;
    @(negedge clk);
    bus.sin    = 1'b0;
    @(negedge clk);
    checkOutput("pre-reset busy", 32'(bus.busy), 32'h1);
    idleLine();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expErr = 0;
    checkOutput("mid-reset busy", 32'(bus.busy), 32'h0);
    checkOutput("mid-reset dvalid", 32'(bus.dvalid), 32'h0);
    checkOutput("mid-reset dout", 32'(bus.dout), 32'h0);
    checkOutput("mid-reset err_cnt", 32'(bus.err_cnt), 32'h0);
    quietDv = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.dvalid) quietDv++;
    end
    checkOutput("post-reset no dvalid", 32'(quietDv), 32'h0);
    applyStimulus(4'h5, 1'b1, 1'b1, 1, busyCyc, dvCyc);
    @(negedge clk);
    idleLine();
    checkOutput("post-reset dvalid", 32'(bus.dvalid), 32'h1);
    checkOutput("post-reset dout", 32'(bus.dout), 32'h5);
    checkOutput("post-reset perr", 32'(bus.perr), 32'h0);

    // Five bad-parity frames walk the 2-bit error counter into saturation.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'h1, 1'b1, 1'b1, 1, busyCyc, dvCyc);
      @(negedge clk);
      idleLine();
      bumpErr(1'b1);
      checkOutput($sformatf("sat%0d perr", k), 32'(bus.perr), 32'h1);
      checkOutput($sformatf("sat%0d err_cnt", k), 32'(bus.err_cnt),
                  CNT_EN ? 32'((k < 3) ? k + 1 : 3) : 32'h0);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
